toggle_pulse_decoder: RTL
=========================

Name: toggle_pulse_decoder

Overview:
Receive-side decoder for a toggle-signalled event line. The transmitter flips its output level once per event. This block synchronises that level into the local clock domain, rejects glitches shorter than a programmable filter length, and regenerates one single-cycle event pulse per accepted level change. It uses a Moore state machine and also keeps a saturating event counter and a glitch indicator.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on tin (legal range 2..4)
FILT_CYCLES, 3, consecutive changed samples required to accept a toggle (legal range 1..15)
CNT_W, 8, width of evt_cnt

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
tin  input  1  toggle line from the transmitter; asynchronous to clk
en  input  1  decode enable
clr_cnt  input  1  synchronous clear of evt_cnt
pout  output  1  one-cycle event pulse per accepted toggle
level  output  1  last accepted (filtered) level of tin
glitch  output  1  one-cycle pulse when a candidate toggle is rejected by the filter
evt_cnt  output  CNT_W  saturating count of accepted toggles
busy  output  1  high while in CONFIRM or PULSE

Behaviour:
- Reset (rst=1 at a clock edge): synchroniser flops=0, ref=0, filter count=0, state=IDLE, evt_cnt=0, glitch=0. Outputs pout=0, level=0, busy=0.
- rst asserted mid-operation: any toggle being confirmed, or any pulse in progress, is dropped. No pout is produced for it.
- Synchroniser: tin passes through SYNC_STAGES flops; the last flop output is tin_s. Nothing else samples tin directly.
- ref: internal accepted level. level = ref at all times.
- FSM states: IDLE, TRACK, CONFIRM, PULSE. Outputs are Moore-decoded from state only: pout=(state==PULSE), busy=(state==CONFIRM or PULSE).
  - IDLE: unconditionally go to TRACK on the next edge. A tin held at 1 through reset is reported as one toggle after reset.
  - TRACK, en=1 and tin_s!=ref: if FILT_CYCLES==1, go to PULSE; otherwise go to CONFIRM and load fcnt=1. Any other case stays in TRACK.
  - CONFIRM, en=0: go to TRACK. No glitch is flagged and ref is unchanged.
  - CONFIRM, tin_s==ref: go to TRACK and pulse glitch=1 for one cycle (registered).
  - CONFIRM, tin_s!=ref: fcnt<=fcnt+1. When fcnt+1==FILT_CYCLES, go to PULSE instead.
  - PULSE: lasts exactly one cycle. On the edge leaving PULSE: ref<=~ref, evt_cnt increments, next state is TRACK.
- Latency: count the first edge that samples the new tin value as edge 1. The state reaches PULSE at edge SYNC_STAGES+FILT_CYCLES (edge 5 with defaults). pout is high for the following cycle. level changes one edge after pout rises.
- Minimum spacing: toggles must be spaced at least FILT_CYCLES+2 cycles apart. A level change arriving during PULSE is evaluated in TRACK against the updated ref. A double toggle within the filter window is therefore reported as a glitch or as nothing, never as two pulses.
- en=0: toggles are not lost. Because ref is held, a level difference that persists while en=0 is detected once en returns to 1. It is then reported FILT_CYCLES (+1 for TRACK) edges later.
- evt_cnt: saturates at 2^CNT_W-1 with no wrap. If clr_cnt and the PULSE increment occur on the same edge, clear wins and the result is 0.
- No combinational path exists from any input to any output.

Test Plan:
- Reset with tin=0: rst high for 2 edges, then low -> pout=0, level=0, glitch=0, evt_cnt=0, busy=0. FSM is in TRACK one edge after rst falls.
- Single toggle, defaults: tin 0->1 and held -> pout=1 for exactly one cycle after edge 5. level=1 one edge later. evt_cnt=1. busy high for 3 cycles.
- Glitch, FILT_CYCLES=3: tin high for 2 cycles then low -> no pout, glitch=1 for exactly one cycle, level=0, evt_cnt=0.
- Toggle train: 10 toggles spaced 8 cycles apart (20-cycle clock period bench) -> exactly 10 single-cycle pout pulses, final level=0, evt_cnt=10, glitch never asserted.
- Enable and reset interaction: en=0, toggle tin to 1, wait 20 cycles -> no pout. Raise en -> pout one cycle after the 4th edge following en rise, evt_cnt=1. Separately, assert rst while in CONFIRM -> no pout, and all outputs return to reset values.
- Counter, CNT_W=4: 20 toggles -> evt_cnt=15 (saturated). Then clr_cnt -> 0. Then assert clr_cnt in the PULSE cycle -> evt_cnt=0 and level still toggles.

Source files
------------

// File: rtl/toggle_pulse_decoder.sv
// Receive-side decoder for a toggle-signalled event line: synchronises tin,
// filters short level changes and emits one pulse per accepted toggle.
module toggle_pulse_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tin,
    input  logic             en,
    input  logic             clr_cnt,
    output logic             pout,
    output logic             level,
    output logic             glitch,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             busy
);

    localparam int unsigned FCNT_W = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_TRACK   = 2'd1;
    localparam logic [1:0] ST_CONFIRM = 2'd2;
    localparam logic [1:0] ST_PULSE   = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tin_s;
    logic                   en_q;
    logic                   ref_q;
    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [FCNT_W-1:0]      fcnt;
    logic [FCNT_W-1:0]      fcnt_next;
    logic [FCNT_W-1:0]      fcnt_inc;
    logic                   glitch_next;

    assign tin_s    = sync_q[SYNC_STAGES-1];
    assign fcnt_inc = fcnt + FCNT_W'(1);
    assign level    = ref_q;

    // Multi-flop synchroniser; the only place tin is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tin};
        end
    end

    // Registered enable so no input reaches the decode logic unflopped.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en;
        end
    end

    // State, filter count, accepted level and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            fcnt   <= '0;
            ref_q  <= 1'b0;
            glitch <= 1'b0;
            pout   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_next;
            fcnt   <= fcnt_next;
            glitch <= glitch_next;
            pout   <= (state_next == ST_PULSE);
            busy   <= (state_next == ST_CONFIRM) || (state_next == ST_PULSE);
            if (state == ST_PULSE) begin
                ref_q <= ~ref_q;
            end
        end
    end

    // Next-state: detect a level change, confirm it for FILT_CYCLES samples.
    always_comb begin
        state_next  = state;
        fcnt_next   = fcnt;
        glitch_next = 1'b0;
        case (state)
            ST_IDLE: begin
                state_next = ST_TRACK;
            end
            ST_TRACK: begin
                if (en_q && (tin_s != ref_q)) begin
                    if (FILT_CYCLES == 1) begin
                        state_next = ST_PULSE;
                    end else begin
                        state_next = ST_CONFIRM;
                        fcnt_next  = FCNT_W'(1);
                    end
                end
            end
            ST_CONFIRM: begin
                if (!en_q) begin
                    state_next = ST_TRACK;
                end else if (tin_s == ref_q) begin
                    state_next  = ST_TRACK;
                    glitch_next = 1'b1;
                end else begin
                    fcnt_next = fcnt_inc;
                    if (fcnt_inc == FCNT_W'(FILT_CYCLES)) begin
                        state_next = ST_PULSE;
                    end
                end
            end
            ST_PULSE: begin
                state_next = ST_TRACK;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Saturating event counter; clear has priority over the increment.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            evt_cnt <= '0;
        end else if ((state == ST_PULSE) && (evt_cnt != {CNT_W{1'b1}})) begin
            evt_cnt <= evt_cnt + CNT_W'(1);
        end
    end

endmodule
